multicycle_cpu: RTL and testbench

Multi-cycle RV32I-subset core that replaces the single-cycle datapath with a state-machine sequencer. It executes one instruction over several cycles, sharing one ALU for address, arithmetic and branch compare. Instruction and data memory sit outside the core behind valid/ready handshakes, so wait-state memories can be attached. It is the top-level processor block, driven by the lab bench or an SoC wrapper.

---
 rtl/multicycle_cpu_if.sv | 27 ++
 rtl/multicycle_cpu.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_if.sv
// rtl/multicycle_cpu_if.sv - instruction and data memory handshake bundle for multicycle_cpu
interface multicycle_cpu_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle RV32I-subset core with one shared ALU
// Define BRANCH_EN to decode beq/bne; otherwise opcode 1100011 traps.
module multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic             clock,
   input  logic             reset,
   multicycle_cpu_if.master bus,
   output logic [31:0]      instruction,
   output logic [31:0]      ALU_result,
   output logic             zero,
   output logic             retire,
   output logic             illegal
);
   localparam int RW = $clog2(NREGS);

   localparam logic [2:0] FETCH     = 3'd0;
   localparam logic [2:0] DECODE    = 3'd1;
   localparam logic [2:0] EXECUTE   = 3'd2;
   localparam logic [2:0] MEM       = 3'd3;
   localparam logic [2:0] WRITEBACK = 3'd4;
   localparam logic [2:0] TRAP      = 3'd5;

   logic [2:0]  state;
   logic [31:0] pc, ir, a, b, alu_q, mdr;
   logic        illegal_q;
   logic [31:0] regs [NREGS];

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7     = ir[31:25];

   function automatic logic reg_ok(input logic [4:0] idx);
      return {27'd0, idx} < 32'(NREGS);
   endfunction

   logic is_r, is_i, is_load, is_store, is_branch, legal;

   always_comb begin
      is_r     = (opcode == 7'b0110011);
      is_i     = (opcode == 7'b0010011);
      is_load  = (opcode == 7'b0000011) && (f3 == 3'b010);
      is_store = (opcode == 7'b0100011) && (f3 == 3'b010);
`ifdef BRANCH_EN
      is_branch = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
`else
      is_branch = 1'b0;
`endif
      legal = 1'b0;
      if (is_r)
         legal = ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)))
                 && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
      else if (is_i) begin
         if (f3 == 3'b001)
            legal = (f7 == 7'b0000000);
         else if (f3 == 3'b101)
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
         else
            legal = 1'b1;
         legal = legal && reg_ok(rd) && reg_ok(rs1);
      end
      else if (is_load)
         legal = reg_ok(rd) && reg_ok(rs1);
      else if (is_store || is_branch)
         legal = reg_ok(rs1) && reg_ok(rs2);
   end

   logic [31:0] imm, op2, alu_out;
   logic [2:0]  alu_f3;
   logic        alt, taken;

   always_comb begin
      if (is_store)
         imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      else if (is_branch)
         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      else
         imm = {{20{ir[31]}}, ir[31:20]};
   end

   // Loads, stores and branches reuse the f3=000 slot: add for addresses, subtract for compares.
   always_comb begin
      op2    = (is_r || is_branch) ? b : imm;
      alu_f3 = (is_r || is_i) ? f3 : 3'b000;
      alt    = is_r ? f7[5] : (is_i && f3 == 3'b101 && f7[5]);
      case (alu_f3)
         3'b000:  alu_out = (alt || is_branch) ? a - op2 : a + op2;
         3'b001:  alu_out = a << op2[4:0];
         3'b010:  alu_out = {31'd0, $signed(a) < $signed(op2)};
         3'b011:  alu_out = {31'd0, a < op2};
         3'b100:  alu_out = a ^ op2;
         3'b101:  alu_out = alt ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
         3'b110:  alu_out = a | op2;
         default: alu_out = a & op2;
      endcase
      taken = is_branch && ((alu_out == 32'd0) != f3[0]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         alu_q     <= '0;
         mdr       <= '0;
         illegal_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            FETCH: if (bus.imem_ready) begin
               ir    <= bus.imem_rdata;
               state <= DECODE;
            end
            DECODE: begin
               a <= regs[rs1[RW-1:0]];
               b <= regs[rs2[RW-1:0]];
               if (legal) state <= EXECUTE;
               else begin
                  state     <= TRAP;
                  illegal_q <= 1'b1;
               end
            end
            EXECUTE: begin
               alu_q <= alu_out;
               if (is_branch) begin
                  pc    <= taken ? pc + imm : pc + 32'd4;
                  state <= FETCH;
               end else if (is_load || is_store) begin
                  if (alu_out[1:0] != 2'b00) begin
                     state     <= TRAP;
                     illegal_q <= 1'b1;
                  end else
                     state <= MEM;
               end else
                  state <= WRITEBACK;
            end
            MEM: if (bus.dmem_ready) begin
               if (is_store) begin
                  pc    <= pc + 32'd4;
                  state <= FETCH;
               end else begin
                  mdr   <= bus.dmem_rdata;
                  state <= WRITEBACK;
               end
            end
            WRITEBACK: begin
               if (rd != 5'd0) regs[rd[RW-1:0]] <= is_load ? mdr : alu_q;
               pc    <= pc + 32'd4;
               state <= FETCH;
            end
            TRAP: state <= TRAP;
            default: begin
               state     <= TRAP;
               illegal_q <= 1'b1;
            end
         endcase
      end
   end

   logic in_mem;
   assign in_mem = (state == MEM);

   assign bus.imem_req   = (state == FETCH);
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = in_mem;
   assign bus.dmem_we    = in_mem && is_store;
   assign bus.dmem_addr  = in_mem ? alu_q : 32'd0;
   assign bus.dmem_wdata = in_mem ? b : 32'd0;

   assign retire = (state == WRITEBACK)
                || (in_mem && is_store && bus.dmem_ready)
                || (state == EXECUTE && is_branch);

   assign instruction = ir;
   assign ALU_result  = alu_q;
   assign zero        = (alu_q == 32'd0);
   assign illegal     = illegal_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed self-checking bench for multicycle_cpu
module tb_multicycle_cpu;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction, ALU_result;
   logic        zero, retire, illegal;
   logic [31:0] instruction16, alu16;
   logic        zero16, retire16, illegal16;

   int vectors = 0;
   int miscompares = 0;
   int dmem_wait = 0;
   int d_cnt = 0;
   int r16_cnt = 0;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];

   always #5 clock = ~clock;

   multicycle_cpu_if bus ();
   multicycle_cpu_if bus16 ();

   multicycle_cpu dut (
      .clock(clock), .reset(reset), .bus(bus),
      .instruction(instruction), .ALU_result(ALU_result), .zero(zero),
      .retire(retire), .illegal(illegal)
   );

   multicycle_cpu #(.NREGS(16)) dut16 (
      .clock(clock), .reset(reset), .bus(bus16),
      .instruction(instruction16), .ALU_result(alu16), .zero(zero16),
      .retire(retire16), .illegal(illegal16)
   );

   assign bus.imem_ready = bus.imem_req;
   assign bus.imem_rdata = imem[bus.imem_addr[7:2]];
   assign bus.dmem_ready = bus.dmem_req && (d_cnt >= dmem_wait);
   assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];

   assign bus16.imem_ready = bus16.imem_req;
   assign bus16.imem_rdata = 32'h002088B3;
   assign bus16.dmem_ready = 1'b0;
   assign bus16.dmem_rdata = 32'd0;

   always @(posedge clock) begin
      if (bus.dmem_req && !bus.dmem_ready) d_cnt <= d_cnt + 1;
      else d_cnt <= 0;
      if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
         dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
      if (retire16) r16_cnt <= r16_cnt + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step_to_retire(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!retire && n < 20);
   endtask

   int n, seen_retire, seen_ireq;

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = 32'd0;
      imem[0]  = 32'h00500093; // addi x1,x0,5
      imem[1]  = 32'h00700113; // addi x2,x0,7
      imem[2]  = 32'h002081B3; // add  x3,x1,x2
      imem[3]  = 32'h40208233; // sub  x4,x1,x2
      imem[4]  = 32'h40125393; // srai x7,x4,1
      imem[5]  = 32'h0040B433; // sltu x8,x1,x4
      imem[6]  = 32'h00302423; // sw   x3,8(x0)
      imem[7]  = 32'h00402623; // sw   x4,12(x0)
      imem[8]  = 32'h00802283; // lw   x5,8(x0)
      imem[9]  = 32'h00502823; // sw   x5,16(x0)
      imem[10] = 32'h00202303; // lw   x6,2(x0)
      repeat (2) tick();

      check("rst_imem_req", bus.imem_req, 1);
      check("rst_imem_addr", bus.imem_addr, 32'h0);
      check("rst_dmem_req", bus.dmem_req, 0);
      check("rst_dmem_we", bus.dmem_we, 0);
      check("rst_dmem_addr", bus.dmem_addr, 32'h0);
      check("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_alu", ALU_result, 32'h0);
      check("rst_zero", zero, 1);
      check("rst_retire", retire, 0);
      check("rst_illegal", illegal, 0);
      reset = 1'b0;

      step_to_retire(n); check("addi1_cycles", n, 3);
      check("addi1_result", ALU_result, 32'd5);
      check("addi1_ir", instruction, 32'h00500093);
      step_to_retire(n); check("addi2_cycles", n, 4);
      check("addi2_result", ALU_result, 32'd7);
      step_to_retire(n); check("add_cycles", n, 4);
      check("add_result", ALU_result, 32'd12);
      check("add_zero", zero, 0);
      step_to_retire(n); check("sub_cycles", n, 4);
      check("sub_result", ALU_result, 32'hFFFF_FFFE);
      step_to_retire(n); check("srai_cycles", n, 4);
      check("srai_result", ALU_result, 32'hFFFF_FFFF);
      step_to_retire(n); check("sltu_cycles", n, 4);
      check("sltu_result", ALU_result, 32'd1);

      dmem_wait = 2;
      repeat (4) tick();
      for (int w = 0; w < 3; w++) begin
         check("sw_wait_req", bus.dmem_req, 1);
         check("sw_wait_we", bus.dmem_we, 1);
         check("sw_wait_addr", bus.dmem_addr, 32'd8);
         check("sw_wait_wdata", bus.dmem_wdata, 32'd12);
         check("sw_wait_retire", retire, (w == 2) ? 1'b1 : 1'b0);
         if (w < 2) tick();
      end
      step_to_retire(n); check("sw2_cycles", n, 6);
      check("sw2_addr", bus.dmem_addr, 32'd12);
      check("sw2_wdata", bus.dmem_wdata, 32'hFFFF_FFFE);
      step_to_retire(n); check("lw_cycles", n, 7);
      check("lw_alu", ALU_result, 32'd8);
      step_to_retire(n); check("sw3_cycles", n, 6);
      check("sw3_addr", bus.dmem_addr, 32'd16);
      check("sw3_wdata_x5", bus.dmem_wdata, 32'd12);

      repeat (3) tick();
      check("mis_exec_illegal", illegal, 0);
      tick();
      check("mis_illegal", illegal, 1);
      check("mis_dmem_req", bus.dmem_req, 0);
      check("mis_alu", ALU_result, 32'd2);
      seen_retire = 0;
      seen_ireq = 0;
      for (int k = 0; k < 6; k++) begin
         if (retire) seen_retire++;
         if (bus.imem_req || bus.dmem_req) seen_ireq++;
         tick();
      end
      check("trap_no_retire", seen_retire, 0);
      check("trap_no_req", seen_ireq, 0);

      reset = 1'b1;
      dmem_wait = 0;
      imem[0] = 32'h00100093; // addi x1,x0,1
      imem[1] = 32'h00000013;
      imem[2] = 32'h00000013;
      imem[3] = 32'h00000013;
      imem[4] = 32'hFE108CE3; // beq x1,x1,-8
      repeat (2) tick();
      check("rst2_illegal", illegal, 0);
      reset = 1'b0;
      step_to_retire(n); check("br_pre0_cycles", n, 3);
      for (int k = 0; k < 3; k++) begin
         step_to_retire(n); check("br_pre_cycles", n, 4);
      end
`ifdef BRANCH_EN
      step_to_retire(n); check("beq_cycles", n, 3);
      tick();
      check("beq_imem_req", bus.imem_req, 1);
      check("beq_target", bus.imem_addr, 32'h08);
`else
      repeat (3) tick();
      check("beq_illegal", illegal, 1);
      check("beq_no_ireq", bus.imem_req, 0);
`endif

      reset = 1'b1;
      imem[0] = 32'h00900093; // addi x1,x0,9
      imem[1] = 32'h00002103; // lw   x2,0(x0)
      dmem_wait = 50;
      repeat (2) tick();
      reset = 1'b0;
      step_to_retire(n); check("rm_addi_cycles", n, 3);
      repeat (6) tick();
      check("rm_pending_req", bus.dmem_req, 1);
      check("rm_pending_ready", bus.dmem_ready, 0);
      reset = 1'b1;
      tick();
      check("rm_dmem_req", bus.dmem_req, 0);
      check("rm_imem_req", bus.imem_req, 1);
      check("rm_imem_addr", bus.imem_addr, 32'h0);
      check("rm_retire", retire, 0);
      imem[0] = 32'h00202223; // sw x2,4(x0)
      imem[1] = 32'h00102423; // sw x1,8(x0)
      dmem_wait = 0;
      tick();
      reset = 1'b0;
      step_to_retire(n); check("rm_sw_cycles", n, 3);
      check("rm_x2_clear", bus.dmem_wdata, 32'h0);
      step_to_retire(n); check("rm_sw2_cycles", n, 4);
      check("rm_x1_clear", bus.dmem_wdata, 32'h0);

      check("n16_illegal", illegal16, 1);
      check("n16_no_retire", r16_cnt, 0);
      check("n16_no_ireq", bus16.imem_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
